w_burst_fifo: RTL

Parametrised AXI write-data (W) channel buffer for the crossbar, placed between a master-side W port and the slave-side W arbiter. It has valid/ready handshakes on both sides, any depth ≥ 2 (power of two not required), occupancy reporting, and a programmable almost-full flag. It also counts buffered complete bursts (WLAST beats), which enables an optional store-and-forward mode so the arbiter never grants a slave to a partially-arrived burst.

---
 rtl/xbar_fifo_pkg.sv | 18 +
 rtl/w_burst_fifo_ptr.sv | 21 ++
 rtl/w_burst_fifo.sv | 114 +++++++++++
 3 files changed

// File: rtl/xbar_fifo_pkg.sv
// Shared crossbar FIFO types and helpers: W-beat record and wrap-around pointer increment.
package xbar_fifo_pkg;

  parameter int W_DATA_WIDTH = 32;
  parameter int W_STRB_WIDTH = W_DATA_WIDTH / 8;

  typedef struct packed {
    logic [W_DATA_WIDTH-1:0] data;
    logic [W_STRB_WIDTH-1:0] strb;
    logic                    last;
  } w_beat_t;

  // Explicit wrap so non-power-of-two depths work.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/w_burst_fifo_ptr.sv
// Wrap-around pointer counter with enable, range 0..DEPTH-1.
module w_burst_fifo_ptr
  import xbar_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          ACLK,
  input  logic          ARESETn,
  input  logic          en,
  output logic [PW-1:0] ptr
);

  always_ff @(posedge ACLK) begin
    if (!ARESETn)
      ptr <= '0;
    else if (en)
      ptr <= PW'(ptr_inc(32'(ptr), DEPTH));
  end

endmodule

// File: rtl/w_burst_fifo.sv
// AXI W-channel buffer with beat/burst occupancy and almost-full flag.
// Define W_FIFO_STORE_FWD_EN to hold beats until their whole burst is buffered.
module w_burst_fifo
  import xbar_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = DEPTH - 2,
  localparam int CW          = $clog2(DEPTH + 1)
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [DATA_WIDTH-1:0] s_WDATA,
  input  logic [STRB_WIDTH-1:0] s_WSTRB,
  input  logic                  s_WLAST,
  input  logic                  s_WVALID,
  output logic                  s_WREADY,
  output logic [DATA_WIDTH-1:0] m_WDATA,
  output logic [STRB_WIDTH-1:0] m_WSTRB,
  output logic                  m_WLAST,
  output logic                  m_WVALID,
  input  logic                  m_WREADY,
  output logic [CW-1:0]         count,
  output logic [CW-1:0]         burst_count,
  output logic                  almost_full,
  output logic                  err_oversize
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
    logic                  last;
  } beat_t;

  beat_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          burst_in;
  logic          burst_out;
  beat_t         head;

  // Ready looks only at registered occupancy, so no path from m_WREADY.
  assign s_WREADY    = ARESETn & (count != CW'(DEPTH));
  assign almost_full = ARESETn & (count >= CW'(AFULL_THRESH));

`ifdef W_FIFO_STORE_FWD_EN
  logic err_q;

  assign m_WVALID     = ARESETn & (count != '0) & (burst_count != '0);
  assign err_oversize = err_q;

  always_ff @(posedge ACLK) begin
    if (!ARESETn)
      err_q <= 1'b0;
    else if ((count == CW'(DEPTH)) && (burst_count == '0))
      err_q <= 1'b1;
  end
`else
  assign m_WVALID     = ARESETn & (count != '0);
  assign err_oversize = 1'b0;
`endif

  assign push      = s_WVALID & s_WREADY;
  assign pop       = m_WVALID & m_WREADY;
  assign burst_in  = push & s_WLAST;
  assign burst_out = pop & m_WLAST;

  w_burst_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .en      (push),
    .ptr     (wr_ptr)
  );

  w_burst_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .en      (pop),
    .ptr     (rd_ptr)
  );

  always_ff @(posedge ACLK) begin
    if (push)
      mem[wr_ptr] <= '{data: s_WDATA, strb: s_WSTRB, last: s_WLAST};
  end

  assign head    = mem[rd_ptr];
  assign m_WDATA = head.data;
  assign m_WSTRB = head.strb;
  assign m_WLAST = head.last;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      count       <= '0;
      burst_count <= '0;
    end else begin
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);

      if (burst_in && !burst_out)
        burst_count <= burst_count + CW'(1);
      else if (burst_out && !burst_in)
        burst_count <= burst_count - CW'(1);
    end
  end

endmodule
